// File: rtl/target_pkg.sv
// Shared types for the shooter target stage: target/direction encodings,
// the packed BCD score type and its increment helper.
package target_pkg;

  typedef enum logic {
    MOVE    = 1'b0,
    EXPLODE = 1'b1
  } tstate_e;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } dir_e;

  // [7:4] tens digit, [3:0] units digit
  typedef logic [7:0] score_t;

  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    if (s[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (s[7:4] == 4'd9) ? 4'd0 : s[7:4] + 4'd1;
    end else begin
      r[7:4] = s[7:4];
      r[3:0] = s[3:0] + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/target_block_if.sv
// Missile-in / target-out bundle between the missile stage, the target
// block and the display stages.
interface target_block_if;
  import target_pkg::*;

  logic [9:0] mpx;
  logic [9:0] mpy;
  logic       mstate;
  logic [9:0] tpx;
  logic [9:0] tpy;
  tstate_e    tstate;
  logic       hit_pulse;
  score_t     score;

  modport master (
    output mpx, mpy, mstate,
    input  tpx, tpy, tstate, hit_pulse, score
  );

  modport slave (
    input  mpx, mpy, mstate,
    output tpx, tpy, tstate, hit_pulse, score
  );

endinterface

// File: rtl/target_block_bcd_counter2.sv
// Two-digit BCD counter, 99 -> 00 wrap; shared with the score display stage.
module bcd_counter2
  import target_pkg::*;
(
  input  logic   game_clk,
  input  logic   reset,
  input  logic   inc,
  output score_t value
);

  // NOTE: non-blocking so every flop samples pre-edge values.
  always_ff @(posedge game_clk) begin
    if (reset) begin
      value <= '0;
    end else if (inc) begin
      value <= bcd_inc(value);
    end
  end

endmodule

// File: rtl/target_block.sv
// Bouncing target with hit detection, explosion/respawn dwell and BCD score.
// Define TGT_SPEEDUP_EN to double the step once the score reaches 10.
module target_block
  import target_pkg::*;
#(
  parameter int BLOCK_SIZE    = 100,
  parameter int TGT_W         = 40,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 600,
  parameter int STEP          = 1,
  parameter int EXPLODE_TICKS = 30
) (
  input  logic           game_clk,
  input  logic           reset,
  target_block_if.slave  bus
);

  localparam int               CNT_W    = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXPLODE_TICKS - 1);
  localparam logic [10:0]      X_MIN11  = 11'(X_MIN);
  localparam logic [10:0]      X_RMAX11 = 11'(X_MAX - TGT_W);
  localparam logic [10:0]      TGT_W11  = 11'(TGT_W);
  localparam logic [9:0]       X_MIN10  = 10'(X_MIN);
  localparam logic [9:0]       X_RMAX10 = 10'(X_MAX - TGT_W);
  localparam logic [9:0]       ROW10    = 10'(BLOCK_SIZE);

  logic [9:0]       tpx_q, tpx_d;
  dir_e             dir_q, dir_d;
  tstate_e          tstate_q, tstate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  score_t           score_q;

  logic [10:0] tpx11, mpx11, step, tpx_sum, tpx_diff;
  logic        hit;

`ifdef TGT_SPEEDUP_EN
  assign step = (score_q[7:4] != 4'd0) ? 11'(2 * STEP) : 11'(STEP);
`else
  assign step = 11'(STEP);
`endif

  // 11-bit compares so tpx + TGT_W cannot wrap near the right edge
  assign tpx11    = {1'b0, tpx_q};
  assign mpx11    = {1'b0, bus.mpx};
  assign tpx_sum  = tpx11 + step;
  assign tpx_diff = tpx11 - step;
  assign hit      = bus.mstate && (bus.mpy == ROW10) &&
                    (tpx11 <= mpx11) && (mpx11 < tpx11 + TGT_W11);

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    tpx_d    = tpx_q;
    dir_d    = dir_q;
    tstate_d = tstate_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    case (tstate_q)
      MOVE: begin
        if (hit) begin
          tstate_d = EXPLODE;
          hit_d    = 1'b1;
          cnt_d    = CNT_LOAD;
        end else if (dir_q == RIGHT) begin
          if (tpx_sum > X_RMAX11) begin
            tpx_d = X_RMAX10;
            dir_d = LEFT;
          end else begin
            tpx_d = tpx_sum[9:0];
          end
        end else begin
          if (tpx11 < X_MIN11 + step) begin
            tpx_d = X_MIN10;
            dir_d = RIGHT;
          end else begin
            tpx_d = tpx_diff[9:0];
          end
        end
      end
      EXPLODE: begin
        // Missile may still sit on the row; hits are ignored until respawn
        if (cnt_q == '0) begin
          tstate_d = MOVE;
          tpx_d    = X_MIN10;
          dir_d    = RIGHT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: tstate_d = MOVE;
    endcase
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      tpx_q    <= X_MIN10;
      dir_q    <= RIGHT;
      tstate_q <= MOVE;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      tpx_q    <= tpx_d;
      dir_q    <= dir_d;
      tstate_q <= tstate_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
    end
  end

  bcd_counter2 u_score (
    .game_clk (game_clk),
    .reset    (reset),
    .inc      (hit_d),
    .value    (score_q)
  );

  assign bus.tpx       = tpx_q;
  assign bus.tpy       = ROW10;
  assign bus.tstate    = tstate_q;
  assign bus.hit_pulse = hit_q;
  assign bus.score     = score_q;

endmodule

// File: tb/tb_target_block.sv
// Randomized bench for target_block against an integer game model.
module tb_target_block;
  import target_pkg::*;

  localparam int ROW  = 100;
  localparam int TW   = 40;
  localparam int RMAX = 600 - 40;
  localparam int DWELL = 30;
`ifdef TGT_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic game_clk = 1'b0;
  logic reset;
  always #5 game_clk = ~game_clk;

  target_block_if bus ();

  target_block dut (
    .game_clk (game_clk),
    .reset    (reset),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // game model: plain integers, decimal score
  int m_tpx, m_dir, m_state, m_cnt, m_score, m_hit;
  int s_ms, s_x, s_y;

  function automatic logic [7:0] m_bcd();
    return {4'(m_score / 10), 4'(m_score % 10)};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {10'(m_tpx), 1'(m_state), 1'(m_hit), m_bcd()};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {bus.tpx, 1'(bus.tstate), bus.hit_pulse, bus.score};
  endfunction

  task automatic model_edge(input bit rst);
    int st;
    if (rst) begin
      m_tpx = 0; m_dir = 0; m_state = 0; m_cnt = 0; m_hit = 0; m_score = 0;
    end else begin
      m_hit = 0;
      if (m_state == 0) begin
        if (s_ms != 0 && s_y == ROW && m_tpx <= s_x && s_x < m_tpx + TW) begin
          m_state = 1; m_hit = 1; m_cnt = DWELL - 1;
          m_score = (m_score + 1) % 100;
        end else begin
          st = (SPEEDUP && m_score >= 10) ? 2 : 1;
          if (m_dir == 0) begin
            if (m_tpx + st > RMAX) begin m_tpx = RMAX; m_dir = 1; end
            else m_tpx += st;
          end else begin
            if (m_tpx < st) begin m_tpx = 0; m_dir = 0; end
            else m_tpx -= st;
          end
        end
      end else if (m_cnt == 0) begin
        m_state = 0; m_tpx = 0; m_dir = 0;
      end else begin
        m_cnt--;
      end
    end
  endtask

  task automatic drive(input int ms, input int x, input int y);
    s_ms = ms; s_x = x; s_y = y;
    bus.mstate = 1'(ms);
    bus.mpx    = 10'(x);
    bus.mpy    = 10'(y);
  endtask

  task automatic tick(input bit rst);
    model_edge(rst);
    reset = rst;
    @(posedge game_clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0);
    tick(1); tick(1);
    checks++; if (bus.tpx !== 10'd0) begin errors++; $display("FAIL reset_tpx got %0d want 0", bus.tpx); end
    checks++; if (bus.tstate !== MOVE) begin errors++; $display("FAIL reset_tstate got %0d want 0", bus.tstate); end
    checks++; if (bus.hit_pulse !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", bus.hit_pulse); end
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL reset_score got %h want 00", bus.score); end
    checks++; if (bus.tpy !== 10'd100) begin errors++; $display("FAIL tpy got %0d want 100", bus.tpy); end
  endtask

  task automatic test_bounce();
    tick(1);
    for (int t = 1; t <= 1130; t++) begin
      drive(0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      tick(0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bounce t=%0d got %h want %h", t, obs_vec(), exp_vec());
      end
      if (t == 560 || t == 562 || t == 1122 || t == 1123) begin
        int want;
        want = (t == 560) ? 560 : (t == 562) ? 559 : (t == 1122) ? 0 : 1;
        checks++;
        if (int'(bus.tpx) != want) begin
          errors++; $display("FAIL bounce_edge t=%0d got %0d want %0d", t, bus.tpx, want);
        end
      end
    end
  endtask

  task automatic test_hit_and_explode();
    drive(0, 0, 0);
    tick(1);
    repeat (200) tick(0);
    drive(1, 220, ROW);
    tick(0);
    checks++;
    if (obs_vec() !== {10'd200, 1'b1, 1'b1, 8'h01}) begin
      errors++; $display("FAIL hit got %h want %h", obs_vec(), {10'd200, 1'b1, 1'b1, 8'h01});
    end
    for (int i = 0; i < DWELL - 1; i++) begin
      tick(0);
      checks++;
      if (obs_vec() !== exp_vec() || bus.tstate !== EXPLODE || bus.hit_pulse !== 1'b0 || bus.score !== 8'h01) begin
        errors++; $display("FAIL explode_hold i=%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    tick(0);
    checks++;
    if (bus.tstate !== MOVE || bus.tpx !== 10'd0 || bus.score !== 8'h01) begin
      errors++; $display("FAIL respawn got tstate=%0d tpx=%0d score=%h want 0 0 01", bus.tstate, bus.tpx, bus.score);
    end
  endtask

  typedef struct { int ms; int x; int y; bit hit; } bcase_t;

  task automatic test_boundaries();
    bcase_t cases[6];
    cases[0] = '{1, 240, 100, 1'b0};
    cases[1] = '{1, 239, 100, 1'b1};
    cases[2] = '{1, 199, 100, 1'b0};
    cases[3] = '{1, 220, 101, 1'b0};
    cases[4] = '{0, 220, 100, 1'b0};
    cases[5] = '{1, 200, 100, 1'b1};
    foreach (cases[k]) begin
      drive(0, 0, 0);
      tick(1);
      repeat (200) tick(0);
      drive(cases[k].ms, cases[k].x, cases[k].y);
      tick(0);
      checks++;
      if (bus.hit_pulse !== cases[k].hit || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL boundary k=%0d mpx=%0d got hit=%b vec=%h want hit=%b vec=%h",
                           k, cases[k].x, bus.hit_pulse, obs_vec(), cases[k].hit, exp_vec());
      end
    end
  endtask

  task automatic hits_until(input int target, inout int hits);
    int budget;
    budget = 40 * (target - hits) + 40;
    while (hits < target && budget > 0) begin
      if (m_state == 0) drive(1, m_tpx + int'($urandom_range(0, TW - 1)), ROW);
      else drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), ROW);
      tick(0);
      budget--;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL score_run hits=%0d got %h want %h", hits, obs_vec(), exp_vec());
      end
      if (m_hit != 0) hits++;
    end
    if (hits < target) begin
      checks++; errors++;
      $display("FAIL score_budget got %0d hits want %0d", hits, target);
    end
  endtask

  task automatic test_score_wrap();
    int hits;
    int p;
    int wait_n;
    hits = 0;
    drive(0, 0, 0);
    tick(1);
    hits_until(9, hits);
    checks++; if (bus.score !== 8'h09) begin errors++; $display("FAIL score9 got %h want 09", bus.score); end
    hits_until(10, hits);
    checks++; if (bus.score !== 8'h10) begin errors++; $display("FAIL score10 got %h want 10", bus.score); end
    drive(0, 0, 0);
    wait_n = 0;
    while (m_state != 0 && wait_n < 40) begin tick(0); wait_n++; end
    checks++;
    if (bus.tstate !== MOVE) begin errors++; $display("FAIL speed_wait got tstate=%0d want 0", bus.tstate); end
    for (int i = 0; i < 4; i++) begin
      p = int'(bus.tpx);
      tick(0);
      checks++;
      if (int'(bus.tpx) - p != (SPEEDUP ? 2 : 1)) begin
        errors++; $display("FAIL speed_step got %0d want %0d", int'(bus.tpx) - p, SPEEDUP ? 2 : 1);
      end
    end
    hits_until(99, hits);
    checks++; if (bus.score !== 8'h99) begin errors++; $display("FAIL score99 got %h want 99", bus.score); end
    hits_until(100, hits);
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL score_wrap got %h want 00", bus.score); end
  endtask

  task automatic test_random();
    drive(0, 0, 0);
    tick(1);
    for (int i = 0; i < 2000; i++) begin
      int x, y;
      bit rst;
      rst = ($urandom_range(0, 99) < 2);
      y = ($urandom_range(0, 3) == 0) ? ROW - 1 + 2 * int'($urandom_range(0, 1)) : ROW;
      x = m_tpx + int'($urandom_range(0, 50)) - 5;
      if (x < 0) x = 0;
      drive(int'($urandom_range(0, 1)), x, y);
      tick(rst);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_explode();
    int n;
    drive(0, 0, 0);
    tick(1);
    drive(1, 10, ROW);
    tick(0);
    n = 0;
    while (m_cnt != 15 && n < 40) begin
      tick(0);
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mid_explode n=%0d got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.tstate !== EXPLODE || m_cnt != 15) begin
      errors++; $display("FAIL mid_explode_setup got tstate=%0d want 1", bus.tstate);
    end
    tick(1);
    checks++;
    if (obs_vec() !== {10'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_mid_explode got %h want %h", obs_vec(), {10'd0, 1'b0, 1'b0, 8'h00});
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0);
    test_reset();
    test_bounce();
    test_hit_and_explode();
    test_boundaries();
    test_score_wrap();
    test_random();
    test_reset_mid_explode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
